bp_resolve_unit: RTL and testbench

//  Downstream partner of the IF-stage branch predictor. Queues each prediction made at fetch,

---
 rtl/bp_resolve_unit.sv | 120 ++++++++++++
 tb/tb_bp_resolve_unit.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/bp_resolve_unit.sv
// rtl/bp_resolve_unit.sv - branch prediction resolve unit: prediction queue, mispredict redirect, statistics
// Queues fetch-time predictions and checks them against EX outcomes; mispredicts redirect and flush.
module bp_resolve_unit #(
  parameter int DEPTH = 4,
  parameter int AW    = 32,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall_i,
  input  logic             pred_valid_i,
  input  logic [AW-1:0]    pred_pc_i,
  input  logic             pred_taken_i,
  input  logic [AW-1:0]    pred_target_i,
  input  logic             ex_valid_i,
  input  logic             ex_is_cond_i,
  input  logic [AW-1:0]    ex_pc_i,
  input  logic             ex_taken_i,
  input  logic [AW-1:0]    ex_target_i,
  output logic [1:0]       branch_taken_o,
  output logic             redirect_o,
  output logic [AW-1:0]    redirect_addr_o,
  output logic             flush_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CNT_W-1:0] branch_cnt_o,
  output logic [CNT_W-1:0] mispred_cnt_o
);

  localparam int PW = $clog2(DEPTH);

  logic [AW-1:0]    pc_q  [DEPTH];
  logic [AW-1:0]    tgt_q [DEPTH];
  logic [DEPTH-1:0] tk_q;

  logic [PW-1:0]    head_q, head_d, tail_q, tail_d;
  logic [PW:0]      count_q, count_d;

  logic [1:0]       code_q;
  logic             redirect_q;
  logic [AW-1:0]    raddr_q;
  logic [CNT_W-1:0] brcnt_q, mpcnt_q;

  logic             ex_go, hit, pop, push, mispred;
  logic             p_taken;
  logic [AW-1:0]    p_target, seq_pc, correct_pc;

  assign full_o  = (count_q == (PW+1)'(DEPTH));
  assign empty_o = (count_q == '0);

  assign ex_go      = ex_valid_i & ~stall_i;
  assign seq_pc     = ex_pc_i + AW'(4);
  assign hit        = ~empty_o & (pc_q[head_q] == ex_pc_i);
  // A branch with no matching head entry was never predicted: it behaves as fall-through.
  assign p_taken    = hit ? tk_q[head_q] : 1'b0;
  assign p_target   = hit ? tgt_q[head_q] : seq_pc;
  assign correct_pc = ex_taken_i ? ex_target_i : seq_pc;
  assign mispred    = ex_go & ((p_taken != ex_taken_i) |
                               (p_taken & ex_taken_i & (p_target != ex_target_i)));
  assign pop        = ex_go & hit;
  assign push       = pred_valid_i & ~stall_i & (~full_o | pop);

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (mispred) begin
      // Everything younger than the mispredicted branch is wrong-path, including this cycle's push.
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (push) tail_d = tail_q + 1'b1;
      if (pop)  head_d = head_q + 1'b1;
      case ({push, pop})
        2'b10:   count_d = count_q + (PW+1)'(1);
        2'b01:   count_d = count_q - (PW+1)'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push & ~mispred) begin
      pc_q[tail_q]  <= pred_pc_i;
      tgt_q[tail_q] <= pred_target_i;
      tk_q[tail_q]  <= pred_taken_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      code_q     <= 2'b00;
      redirect_q <= 1'b0;
      raddr_q    <= '0;
      brcnt_q    <= '0;
      mpcnt_q    <= '0;
    end else begin
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      code_q     <= (ex_go & ex_is_cond_i) ? (ex_taken_i ? 2'b10 : 2'b01) : 2'b00;
      redirect_q <= mispred;
      raddr_q    <= mispred ? correct_pc : '0;
      if (ex_go & ex_is_cond_i & (brcnt_q != '1)) brcnt_q <= brcnt_q + CNT_W'(1);
      if (mispred & (mpcnt_q != '1))              mpcnt_q <= mpcnt_q + CNT_W'(1);
    end
  end

  assign branch_taken_o  = code_q;
  assign redirect_o      = redirect_q;
  assign flush_o         = redirect_q;
  assign redirect_addr_o = raddr_q;
  assign branch_cnt_o    = brcnt_q;
  assign mispred_cnt_o   = mpcnt_q;

endmodule

// File: tb/tb_bp_resolve_unit.sv
// tb/tb_bp_resolve_unit.sv - scoreboard testbench for bp_resolve_unit
module tb_bp_resolve_unit;

  localparam int AW    = 32;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             stall_i;
  logic             pred_valid_i;
  logic [AW-1:0]    pred_pc_i;
  logic             pred_taken_i;
  logic [AW-1:0]    pred_target_i;
  logic             ex_valid_i;
  logic             ex_is_cond_i;
  logic [AW-1:0]    ex_pc_i;
  logic             ex_taken_i;
  logic [AW-1:0]    ex_target_i;
  logic [1:0]       branch_taken_o;
  logic             redirect_o;
  logic [AW-1:0]    redirect_addr_o;
  logic             flush_o;
  logic             full_o;
  logic             empty_o;
  logic [CNT_W-1:0] branch_cnt_o;
  logic [CNT_W-1:0] mispred_cnt_o;

  bp_resolve_unit #(.DEPTH(4), .AW(AW), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .stall_i(stall_i),
    .pred_valid_i(pred_valid_i), .pred_pc_i(pred_pc_i),
    .pred_taken_i(pred_taken_i), .pred_target_i(pred_target_i),
    .ex_valid_i(ex_valid_i), .ex_is_cond_i(ex_is_cond_i), .ex_pc_i(ex_pc_i),
    .ex_taken_i(ex_taken_i), .ex_target_i(ex_target_i),
    .branch_taken_o(branch_taken_o), .redirect_o(redirect_o),
    .redirect_addr_o(redirect_addr_o), .flush_o(flush_o),
    .full_o(full_o), .empty_o(empty_o),
    .branch_cnt_o(branch_cnt_o), .mispred_cnt_o(mispred_cnt_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]    code;
    logic          redir;
    logic [AW-1:0] addr;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string name, input logic [AW-1:0] act, input logic [AW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: any visible outcome pops the oldest expectation.
  always @(negedge clk) begin
    if (!rst && (redirect_o || branch_taken_o != 2'b00)) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_output: code=%b redirect=%b addr=0x%0h expected none",
                 branch_taken_o, redirect_o, redirect_addr_o);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("branch_taken_o", AW'(branch_taken_o), AW'(e.code));
        check("redirect_o", AW'(redirect_o), AW'(e.redir));
        check("flush_o", AW'(flush_o), AW'(e.redir));
        check("redirect_addr_o", redirect_addr_o, e.addr);
      end
    end
  end

  task automatic apply(input logic pv, input logic [AW-1:0] ppc, input logic ptk,
                       input logic [AW-1:0] ptg, input logic ev, input logic ec,
                       input logic [AW-1:0] epc, input logic etk, input logic [AW-1:0] etg,
                       input logic stl, input logic [1:0] xcode, input logic xredir,
                       input logic [AW-1:0] xaddr);
    @(negedge clk);
    pred_valid_i = pv;  pred_pc_i = ppc; pred_taken_i = ptk; pred_target_i = ptg;
    ex_valid_i   = ev;  ex_is_cond_i = ec; ex_pc_i = epc; ex_taken_i = etk; ex_target_i = etg;
    stall_i      = stl;
    if (xcode != 2'b00 || xredir) sb.push_back('{code: xcode, redir: xredir, addr: xaddr});
  endtask

  task automatic push_pred(input logic [AW-1:0] pc, input logic tk, input logic [AW-1:0] tg);
    apply(1'b1, pc, tk, tg, 1'b0, 1'b0, '0, 1'b0, '0, 1'b0, 2'b00, 1'b0, '0);
  endtask

  task automatic settle();
    @(negedge clk);
    rst = 1'b0;
    pred_valid_i = 1'b0; ex_valid_i = 1'b0; stall_i = 1'b0;
  endtask

  initial begin
    rst = 1'b1; stall_i = 1'b0;
    pred_valid_i = 1'b0; pred_pc_i = '0; pred_taken_i = 1'b0; pred_target_i = '0;
    ex_valid_i = 1'b0; ex_is_cond_i = 1'b0; ex_pc_i = '0; ex_taken_i = 1'b0; ex_target_i = '0;
    repeat (2) @(negedge clk);
    settle();
    check("rst_empty", AW'(empty_o), 1);
    check("rst_full", AW'(full_o), 0);
    check("rst_redirect", AW'(redirect_o), 0);
    check("rst_code", AW'(branch_taken_o), 0);
    check("rst_brcnt", AW'(branch_cnt_o), 0);
    check("rst_mpcnt", AW'(mispred_cnt_o), 0);

    // Correct taken prediction
    push_pred(32'h100, 1'b1, 32'h140);
    apply(0, '0, 0, '0, 1, 1, 32'h100, 1, 32'h140, 0, 2'b10, 0, '0);
    settle();
    check("t1_empty", AW'(empty_o), 1);
    check("t1_brcnt", AW'(branch_cnt_o), 1);
    check("t1_mpcnt", AW'(mispred_cnt_o), 0);

    // Direction mispredict
    push_pred(32'h200, 1'b0, 32'h204);
    apply(0, '0, 0, '0, 1, 1, 32'h200, 1, 32'h180, 0, 2'b10, 1, 32'h180);
    settle();
    check("t2_empty", AW'(empty_o), 1);
    check("t2_mpcnt", AW'(mispred_cnt_o), 1);

    // Fill, overflow push, pop+push while full, in-order drain across pointer wrap
    for (int i = 0; i < 4; i++) push_pred(32'h10 + 4 * i, 1'b1, 32'h50 + 4 * i);
    settle();
    check("t3_full", AW'(full_o), 1);
    push_pred(32'h20, 1'b1, 32'h60);
    apply(1, 32'h24, 1, 32'h64, 1, 1, 32'h10, 1, 32'h50, 0, 2'b10, 0, '0);
    settle();
    check("t3_full_after_pushpop", AW'(full_o), 1);
    for (int i = 1; i < 4; i++)
      apply(0, '0, 0, '0, 1, 1, 32'h10 + 4 * i, 1, 32'h50 + 4 * i, 0, 2'b10, 0, '0);
    settle();
    check("t3_not_empty", AW'(empty_o), 0);
    check("t3_not_full", AW'(full_o), 0);
    apply(0, '0, 0, '0, 1, 1, 32'h24, 1, 32'h64, 0, 2'b10, 0, '0);
    settle();
    check("t3_empty", AW'(empty_o), 1);
    check("t3_brcnt", AW'(branch_cnt_o), 7);
    check("t3_mpcnt", AW'(mispred_cnt_o), 1);

    // Unpredicted branches, jal, address wrap, target mismatch
    apply(0, '0, 0, '0, 1, 1, 32'h300, 1, 32'h400, 0, 2'b10, 1, 32'h400);
    apply(0, '0, 0, '0, 1, 1, 32'h300, 0, 32'h400, 0, 2'b01, 0, '0);
    apply(0, '0, 0, '0, 1, 0, 32'h308, 1, 32'h500, 0, 2'b00, 1, 32'h500);
    push_pred(32'hFFFF_FFFC, 1'b1, 32'h0000_0000);
    apply(0, '0, 0, '0, 1, 1, 32'hFFFF_FFFC, 0, 32'h0000_0000, 0, 2'b01, 1, 32'h0);
    push_pred(32'h600, 1'b1, 32'h640);
    apply(0, '0, 0, '0, 1, 1, 32'h600, 1, 32'h680, 0, 2'b10, 1, 32'h680);
    settle();
    check("t4_brcnt", AW'(branch_cnt_o), 11);
    check("t4_mpcnt", AW'(mispred_cnt_o), 5);

    // Stall blocks push, resolve and statistics
    apply(1, 32'h700, 1, 32'h740, 1, 1, 32'h700, 1, 32'h900, 1, 2'b00, 0, '0);
    settle();
    check("stall_empty", AW'(empty_o), 1);
    check("stall_brcnt", AW'(branch_cnt_o), 11);
    check("stall_mpcnt", AW'(mispred_cnt_o), 5);

    // Mispredict drops a simultaneous push
    push_pred(32'h800, 1'b0, 32'h804);
    apply(1, 32'h804, 0, 32'h808, 1, 1, 32'h800, 1, 32'h900, 0, 2'b10, 1, 32'h900);
    settle();
    check("t5_empty", AW'(empty_o), 1);
    check("t5_brcnt", AW'(branch_cnt_o), 12);
    check("t5_mpcnt", AW'(mispred_cnt_o), 6);

    // Reset mid-stream
    push_pred(32'hA00, 1'b1, 32'hA40);
    push_pred(32'hA04, 1'b1, 32'hA44);
    apply(0, '0, 0, '0, 1, 1, 32'hA00, 0, '0, 0, 2'b00, 0, '0);
    rst = 1'b1;
    settle();
    check("mrst_empty", AW'(empty_o), 1);
    check("mrst_code", AW'(branch_taken_o), 0);
    check("mrst_redirect", AW'(redirect_o), 0);
    check("mrst_flush", AW'(flush_o), 0);
    check("mrst_addr", redirect_addr_o, 0);
    check("mrst_brcnt", AW'(branch_cnt_o), 0);
    check("mrst_mpcnt", AW'(mispred_cnt_o), 0);

    // Saturation of both counters
    for (int i = 0; i < 17; i++)
      apply(0, '0, 0, '0, 1, 0, 32'h1000, 1, 32'h2000, 0, 2'b00, 1, 32'h2000);
    settle();
    check("sat_mpcnt", AW'(mispred_cnt_o), 32'hF);
    check("sat_brcnt_idle", AW'(branch_cnt_o), 0);
    for (int i = 0; i < 17; i++)
      apply(0, '0, 0, '0, 1, 1, 32'h1100, 0, '0, 0, 2'b01, 0, '0);
    settle();
    check("sat_brcnt", AW'(branch_cnt_o), 32'hF);
    check("sat_mpcnt_hold", AW'(mispred_cnt_o), 32'hF);

    repeat (3) settle();
    check("sb_drain", AW'(sb.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
